// File: rtl/softex_tcdm_responder_pkg.sv
// Shared types and constants for the SoftEx TCDM responder.
package softex_tcdm_responder_pkg;

    localparam int unsigned TCDM_ID_W       = 8;
    localparam logic [15:0] TCDM_STALL_SEED = 16'hACE1;

    typedef struct packed {
        logic [31:0]          data;
        logic [TCDM_ID_W-1:0] id;
        logic                 opc;
    } tcdm_resp_t;

    // Fibonacci LFSR, taps 16,14,13,11
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/softex_tcdm_responder_if.sv
// Multi-port TCDM request/response bundle between the SoftEx wrapper and a slave memory.
interface softex_tcdm_responder_if #(
    parameter int unsigned MP   = 4,
    parameter int unsigned ID_W = 8
);
    logic [MP-1:0]           req;
    logic [MP-1:0]           gnt;
    logic [MP-1:0][31:0]     add;
    logic [MP-1:0]           wen;
    logic [MP-1:0][3:0]      be;
    logic [MP-1:0][31:0]     data;
    logic [MP-1:0][ID_W-1:0] id;
    logic [MP-1:0]           r_ready;
    logic [MP-1:0]           r_valid;
    logic [MP-1:0][31:0]     r_data;
    logic [MP-1:0][ID_W-1:0] r_id;
    logic [MP-1:0]           r_opc;

    modport master (
        output req, add, wen, be, data, id, r_ready,
        input  gnt, r_valid, r_data, r_id, r_opc
    );

    modport slave (
        input  req, add, wen, be, data, id, r_ready,
        output gnt, r_valid, r_data, r_id, r_opc
    );
endinterface

// File: rtl/softex_tcdm_responder_resp_fifo.sv
// Two-entry response FIFO for one TCDM port; head is visible while count != 0.
module softex_tcdm_resp_fifo
    import softex_tcdm_responder_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  tcdm_resp_t data_i,
    input  logic       pop_i,
    output tcdm_resp_t head_o,
    output logic [1:0] count_o
);
    tcdm_resp_t mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/softex_tcdm_responder.sv
// Multi-port TCDM slave memory with per-port response FIFOs.
// Optional SOFTEX_TCDM_STALL_EN adds pseudo-random grant stalls per port.
module softex_tcdm_responder
    import softex_tcdm_responder_pkg::*;
#(
    parameter int unsigned MP        = 4,
    parameter int unsigned N_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int unsigned ID_W      = TCDM_ID_W
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    softex_tcdm_responder_if.slave  tcdm
);
    localparam int unsigned AW   = $clog2(N_WORDS);
    localparam logic [32:0] SPAN = 33'(N_WORDS) << 2;

    logic [31:0]   mem_q [N_WORDS];
    logic [32:0]   off      [MP];
    logic [AW-1:0] idx      [MP];
    logic          in_range [MP];
    logic          stall_ok [MP];
    tcdm_resp_t    push_data[MP];
    tcdm_resp_t    head     [MP];
    logic [1:0]    count    [MP];
    logic [MP-1:0] gnt, push, pop, r_valid;

    for (genvar p = 0; p < MP; p++) begin : g_port
        // A negative offset sets bit 32 and therefore also fails the span compare
        assign off[p]      = {1'b0, tcdm.add[p]} - {1'b0, BASE_ADDR};
        assign in_range[p] = off[p] < SPAN;
        assign idx[p]      = off[p][AW+1:2];

        assign push_data[p] = '{data: in_range[p] ? mem_q[idx[p]] : 32'h0,
                                id:   tcdm.id[p],
                                opc:  ~in_range[p]};

`ifdef SOFTEX_TCDM_STALL_EN
        logic [15:0] lfsr_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) lfsr_q <= TCDM_STALL_SEED ^ 16'(p);
            else         lfsr_q <= lfsr_next(lfsr_q);
        end
        assign stall_ok[p] = lfsr_q[1:0] != 2'b00;
`else
        assign stall_ok[p] = 1'b1;
`endif

        softex_tcdm_resp_fifo i_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (push[p]),
            .data_i  (push_data[p]),
            .pop_i   (pop[p]),
            .head_o  (head[p]),
            .count_o (count[p])
        );
    end

    always_comb begin
        gnt     = '0;
        push    = '0;
        pop     = '0;
        r_valid = '0;
        for (int p = 0; p < MP; p++) begin
            gnt[p]     = tcdm.req[p] & ~count[p][1] & stall_ok[p];
            push[p]    = gnt[p] & tcdm.wen[p];
            r_valid[p] = count[p] != 2'd0;
            pop[p]     = r_valid[p] & tcdm.r_ready[p];
        end
    end

    always_comb begin
        tcdm.r_data = '0;
        tcdm.r_id   = '0;
        tcdm.r_opc  = '0;
        for (int p = 0; p < MP; p++) begin
            tcdm.r_data[p] = head[p].data;
            tcdm.r_id[p]   = head[p].id;
            tcdm.r_opc[p]  = head[p].opc;
        end
    end

    assign tcdm.gnt     = gnt;
    assign tcdm.r_valid = r_valid;

    // Ascending port loop: the last NBA to a byte wins, so the highest port index takes it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < N_WORDS; w++) mem_q[w] <= 32'h0;
        end else begin
            for (int p = 0; p < MP; p++) begin
                if (gnt[p] && !tcdm.wen[p] && in_range[p]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (tcdm.be[p][b]) mem_q[idx[p]][8*b +: 8] <= tcdm.data[p][8*b +: 8];
                    end
                end
            end
        end
    end
endmodule
